autenticacao_pin: RTL and testbench
===================================

# autenticacao_pin

PIN-authentication front end for the ATM datapath: collects keypad digits for an inserted card, compares them against the card's stored PIN, counts failed attempts and runs the entry timeout. It sits directly upstream of the balance/withdrawal schematic. It produces the session grant (`autorizado`), the 9-bit remaining-time value (`tempo`) and the two card-eject pulses (`ejeta_tentativa`, `ejeta_tempo`) that the downstream stage displays and acts on.

## Interface
- `N_DIGITOS`, 4: number of PIN digits; range 1..4.
- `MAX_TENTATIVAS`, 3: number of failed confirms that triggers an eject; range 1..3.
- `TIMEOUT_CICLOS`, 300: entry timeout in clock cycles; range 1..511.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cartao_in`  in  1  level; card present.
- `digito`  in  4  BCD digit, 0..9; values 10..15 are ignored.
- `digito_valido`  in  1  one-cycle strobe qualifying `digito`.
- `confirma`  in  1  one-cycle strobe; submit the PIN.
- `cancela`  in  1  one-cycle strobe; clear entry, or end the session.
- `pin_ref`  in  16  stored PIN, first digit in [15:12]; only the top `N_DIGITOS` nibbles are compared.
- `autorizado`  out  1  level; session granted.
- `erro_pin`  out  1  one-cycle pulse; wrong PIN, retry allowed.
- `ejeta_tentativa`  out  1  one-cycle pulse; attempts exhausted.
- `ejeta_tempo`  out  1  one-cycle pulse; entry timed out.
- `tempo`  out  9  remaining entry cycles.
- `tentativas`  out  2  failed attempts so far.
- `n_digitos`  out  3  digits currently buffered.

## Operation
- States: ESPERA, ENTRADA, VERIFICA, AUTORIZADO, EJETA.
- ESPERA → ENTRADA when `cartao_in`=1.
  - On entry: buffer and `n_digitos` cleared, `tentativas`=0, `tempo`=`TIMEOUT_CICLOS`.
- ENTRADA handles one event per cycle, in this priority order:
  1. `cartao_in`=0 → ESPERA.
  2. `cancela` → clear buffer; reload `tempo`; no attempt is counted.
  3. `tempo`=0 → pulse `ejeta_tempo`; go to EJETA.
  4. `confirma` → VERIFICA.
  5. `digito_valido` with `digito`≤9 and `n_digitos`<`N_DIGITOS` → shift the digit in (the first digit ends up in the top nibble), increment `n_digitos`, reload `tempo`.
  6. Otherwise, `tempo` decrements.
  - Extra digits and invalid digits are dropped, and `tempo` is not reloaded for them.
- VERIFICA lasts exactly one cycle. Match = (`n_digitos`=`N_DIGITOS`) AND the buffer equals the top `N_DIGITOS` nibbles of `pin_ref`.
  - Match → AUTORIZADO.
  - Mismatch → increment `tentativas`.
    - New count = `MAX_TENTATIVAS` → pulse `ejeta_tentativa`; go to EJETA.
    - Otherwise → pulse `erro_pin`; clear buffer; reload `tempo`; go to ENTRADA.
  - `cartao_in`=0 during VERIFICA → ESPERA; no pulse is issued.
- AUTORIZADO: `autorizado`=1; `tempo` holds 0.
  - `cancela` → EJETA.
  - `cartao_in`=0 → ESPERA.
- EJETA: all strobes are ignored; `cartao_in`=0 → ESPERA.
- Card removal in any state → ESPERA. Counters clear on the next entry into ENTRADA.

## Timing
- Reset (async assert, synchronous-release use):
  - state=ESPERA.
  - All outputs 0: `tempo`=0, `tentativas`=0, `n_digitos`=0.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- `cartao_in` sampled at edge E → state is ENTRADA and `tempo`=`TIMEOUT_CICLOS` after E.
- `confirma` sampled at edge E → VERIFICA after E → result is visible after E+1:
  - `autorizado` rises, or
  - `erro_pin` / `ejeta_tentativa` is high for exactly the cycle following E+1.
- Timeout: with no events, `ejeta_tempo` pulses `TIMEOUT_CICLOS`+1 edges after the last reload.
- A reset mid-session aborts immediately. No pulse is emitted.

## Test plan
- Correct PIN: reset, `pin_ref`=16'h1234, card in, digits 1,2,3,4, confirma → `autorizado`=1 two edges after confirma; `tentativas`=0.
- Retry then success: digits 1,2,3,5 + confirma → one `erro_pin` pulse, `tentativas`=1, `n_digitos`=0. Then 1,2,3,4 + confirma → `autorizado`=1.
- Attempt limit: three wrong confirms → two `erro_pin` pulses, then a single `ejeta_tentativa` pulse, state EJETA. Further digits are ignored until `cartao_in`=0, then state is ESPERA.
- Timeout: `TIMEOUT_CICLOS`=20, card in, one digit at cycle 5, then idle → `tempo` reloads to 20 at the digit and `ejeta_tempo` pulses 21 edges later. A digit and a timeout in the same cycle → timeout wins.
- Edge inputs: five digits entered → `n_digitos` saturates at 4. `digito`=4'hA is ignored. Confirm with 3 digits → counted as a failed attempt. `cancela` and `confirma` in the same cycle → buffer cleared, no attempt counted.
- Abort: card removed in VERIFICA → no pulse, state ESPERA. `rst_n` low mid-entry → all outputs 0 asynchronously.

Source files
------------

// File: rtl/autenticacao_pin.sv
// PIN-authentication front end: collects keypad digits for an inserted card,
// checks them against the stored PIN, counts failed attempts and runs the entry timeout.
module autenticacao_pin #(
    parameter int unsigned N_DIGITOS      = 4,
    parameter int unsigned MAX_TENTATIVAS = 3,
    parameter int unsigned TIMEOUT_CICLOS = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cartao_in,
    input  logic [3:0]  digito,
    input  logic        digito_valido,
    input  logic        confirma,
    input  logic        cancela,
    input  logic [15:0] pin_ref,
    output logic        autorizado,
    output logic        erro_pin,
    output logic        ejeta_tentativa,
    output logic        ejeta_tempo,
    output logic [8:0]  tempo,
    output logic [1:0]  tentativas,
    output logic [2:0]  n_digitos
);

    localparam int unsigned BUF_W   = 4 * N_DIGITOS;
    localparam logic [8:0]  T_CARGA = 9'(TIMEOUT_CICLOS);
    localparam logic [2:0]  N_MAX   = 3'(N_DIGITOS);
    localparam logic [1:0]  T_MAX   = 2'(MAX_TENTATIVAS);

    typedef enum logic [2:0] {
        ESPERA,
        ENTRADA,
        VERIFICA,
        AUTORIZADO,
        EJETA
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [2:0]         n_q, n_d;
    logic [1:0]         tent_q, tent_d;
    logic [8:0]         tempo_q, tempo_d;
    logic               autorizado_q, autorizado_d;
    logic               erro_q, erro_d;
    logic               ej_tent_q, ej_tent_d;
    logic               ej_tempo_q, ej_tempo_d;
    logic               pin_ok;
    logic               digito_ok;

    // Full-length entry whose buffer matches the top nibbles of the stored PIN
    assign pin_ok    = (n_q == N_MAX) && (buf_q == pin_ref[15 -: BUF_W]);
    assign digito_ok = digito_valido && (digito <= 4'd9) && (n_q < N_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= ESPERA;
            buf_q        <= '0;
            n_q          <= '0;
            tent_q       <= '0;
            tempo_q      <= '0;
            autorizado_q <= 1'b0;
            erro_q       <= 1'b0;
            ej_tent_q    <= 1'b0;
            ej_tempo_q   <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            buf_q        <= buf_d;
            n_q          <= n_d;
            tent_q       <= tent_d;
            tempo_q      <= tempo_d;
            autorizado_q <= autorizado_d;
            erro_q       <= erro_d;
            ej_tent_q    <= ej_tent_d;
            ej_tempo_q   <= ej_tempo_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        buf_d      = buf_q;
        n_d        = n_q;
        tent_d     = tent_q;
        tempo_d    = tempo_q;
        erro_d     = 1'b0;
        ej_tent_d  = 1'b0;
        ej_tempo_d = 1'b0;

        case (estado_q)
            ESPERA: begin
                if (cartao_in) begin
                    estado_d = ENTRADA;
                    buf_d    = '0;
                    n_d      = '0;
                    tent_d   = '0;
                    tempo_d  = T_CARGA;
                end
            end
            // One event per cycle; the if-chain order is the event priority
            ENTRADA: begin
                if (!cartao_in) begin
                    estado_d = ESPERA;
                end else if (cancela) begin
                    buf_d   = '0;
                    n_d     = '0;
                    tempo_d = T_CARGA;
                end else if (tempo_q == 9'd0) begin
                    ej_tempo_d = 1'b1;
                    estado_d   = EJETA;
                end else if (confirma) begin
                    estado_d = VERIFICA;
                end else if (digito_ok) begin
                    buf_d   = BUF_W'({buf_q, digito});
                    n_d     = n_q + 3'd1;
                    tempo_d = T_CARGA;
                end else begin
                    tempo_d = tempo_q - 9'd1;
                end
            end
            VERIFICA: begin
                if (!cartao_in) begin
                    estado_d = ESPERA;
                end else if (pin_ok) begin
                    estado_d = AUTORIZADO;
                    tempo_d  = '0;
                end else begin
                    tent_d = tent_q + 2'd1;
                    if (tent_d == T_MAX) begin
                        ej_tent_d = 1'b1;
                        estado_d  = EJETA;
                    end else begin
                        erro_d   = 1'b1;
                        buf_d    = '0;
                        n_d      = '0;
                        tempo_d  = T_CARGA;
                        estado_d = ENTRADA;
                    end
                end
            end
            AUTORIZADO: begin
                tempo_d = '0;
                if (!cartao_in) begin
                    estado_d = ESPERA;
                end else if (cancela) begin
                    estado_d = EJETA;
                end
            end
            EJETA: begin
                if (!cartao_in) begin
                    estado_d = ESPERA;
                end
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase
    end

    assign autorizado_d    = (estado_d == AUTORIZADO);

    assign autorizado      = autorizado_q;
    assign erro_pin        = erro_q;
    assign ejeta_tentativa = ej_tent_q;
    assign ejeta_tempo     = ej_tempo_q;
    assign tempo           = tempo_q;
    assign tentativas      = tent_q;
    assign n_digitos       = n_q;

endmodule

// File: tb/tb_autenticacao_pin.sv
// Directed bench for autenticacao_pin, built with a 20-cycle entry timeout.
module tb_autenticacao_pin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cartao_in;
    logic [3:0]  digito;
    logic        digito_valido;
    logic        confirma;
    logic        cancela;
    logic [15:0] pin_ref;
    logic        autorizado;
    logic        erro_pin;
    logic        ejeta_tentativa;
    logic        ejeta_tempo;
    logic [8:0]  tempo;
    logic [1:0]  tentativas;
    logic [2:0]  n_digitos;

    int n_cmp = 0;
    int n_err = 0;

    autenticacao_pin #(
        .N_DIGITOS(4),
        .MAX_TENTATIVAS(3),
        .TIMEOUT_CICLOS(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cartao_in(cartao_in),
        .digito(digito),
        .digito_valido(digito_valido),
        .confirma(confirma),
        .cancela(cancela),
        .pin_ref(pin_ref),
        .autorizado(autorizado),
        .erro_pin(erro_pin),
        .ejeta_tentativa(ejeta_tentativa),
        .ejeta_tempo(ejeta_tempo),
        .tempo(tempo),
        .tentativas(tentativas),
        .n_digitos(n_digitos)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        digito        = d;
        digito_valido = 1'b1;
        tick();
        digito_valido = 1'b0;
    endtask

    task automatic pulse_confirma();
        confirma = 1'b1;
        tick();
        confirma = 1'b0;
    endtask

    task automatic card_in();
        cartao_in = 1'b1;
        tick();
    endtask

    task automatic card_out();
        cartao_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cartao_in = 1'b0; digito = '0; digito_valido = 1'b0;
        confirma = 1'b0; cancela = 1'b0; pin_ref = 16'h1234;
        tick(); tick();
        n_cmp++; if (autorizado !== 1'b0) begin n_err++; $display("FAIL rst_autorizado got %0d exp 0", autorizado); end
        n_cmp++; if (erro_pin !== 1'b0) begin n_err++; $display("FAIL rst_erro_pin got %0d exp 0", erro_pin); end
        n_cmp++; if (ejeta_tentativa !== 1'b0) begin n_err++; $display("FAIL rst_ejeta_tentativa got %0d exp 0", ejeta_tentativa); end
        n_cmp++; if (ejeta_tempo !== 1'b0) begin n_err++; $display("FAIL rst_ejeta_tempo got %0d exp 0", ejeta_tempo); end
        n_cmp++; if (tempo !== 9'd0) begin n_err++; $display("FAIL rst_tempo got %0d exp 0", tempo); end
        n_cmp++; if (tentativas !== 2'd0) begin n_err++; $display("FAIL rst_tentativas got %0d exp 0", tentativas); end
        n_cmp++; if (n_digitos !== 3'd0) begin n_err++; $display("FAIL rst_n_digitos got %0d exp 0", n_digitos); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_correct_pin();
        card_in();
        n_cmp++; if (tempo !== 9'd20) begin n_err++; $display("FAIL ok_tempo_load got %0d exp 20", tempo); end
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
        n_cmp++; if (n_digitos !== 3'd4) begin n_err++; $display("FAIL ok_n_digitos got %0d exp 4", n_digitos); end
        pulse_confirma();
        n_cmp++; if (autorizado !== 1'b0) begin n_err++; $display("FAIL ok_autorizado_early got %0d exp 0", autorizado); end
        tick();
        n_cmp++; if (autorizado !== 1'b1) begin n_err++; $display("FAIL ok_autorizado got %0d exp 1", autorizado); end
        n_cmp++; if (tentativas !== 2'd0) begin n_err++; $display("FAIL ok_tentativas got %0d exp 0", tentativas); end
        n_cmp++; if (tempo !== 9'd0) begin n_err++; $display("FAIL ok_tempo_zero got %0d exp 0", tempo); end
        card_out();
        n_cmp++; if (autorizado !== 1'b0) begin n_err++; $display("FAIL ok_autorizado_removed got %0d exp 0", autorizado); end
    endtask

    task automatic test_retry();
        card_in();
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd5);
        pulse_confirma();
        n_cmp++; if (erro_pin !== 1'b0) begin n_err++; $display("FAIL retry_erro_early got %0d exp 0", erro_pin); end
        tick();
        n_cmp++; if (erro_pin !== 1'b1) begin n_err++; $display("FAIL retry_erro_pin got %0d exp 1", erro_pin); end
        n_cmp++; if (tentativas !== 2'd1) begin n_err++; $display("FAIL retry_tentativas got %0d exp 1", tentativas); end
        n_cmp++; if (n_digitos !== 3'd0) begin n_err++; $display("FAIL retry_n_digitos got %0d exp 0", n_digitos); end
        n_cmp++; if (tempo !== 9'd20) begin n_err++; $display("FAIL retry_tempo got %0d exp 20", tempo); end
        tick();
        n_cmp++; if (erro_pin !== 1'b0) begin n_err++; $display("FAIL retry_erro_width got %0d exp 0", erro_pin); end
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
        pulse_confirma(); tick();
        n_cmp++; if (autorizado !== 1'b1) begin n_err++; $display("FAIL retry_autorizado got %0d exp 1", autorizado); end
        cancela = 1'b1; tick(); cancela = 1'b0;
        n_cmp++; if (autorizado !== 1'b0) begin n_err++; $display("FAIL retry_cancel_session got %0d exp 0", autorizado); end
        card_out();
    endtask

    task automatic test_attempt_limit();
        card_in();
        for (int k = 0; k < 3; k++) begin
            press_digit(4'd9); press_digit(4'd9); press_digit(4'd9);
            if (k < 2) press_digit(4'd9);
            pulse_confirma(); tick();
            n_cmp++; if (erro_pin !== (k < 2)) begin n_err++; $display("FAIL lim_erro_pin_%0d got %0d exp %0d", k, erro_pin, (k < 2)); end
            n_cmp++; if (ejeta_tentativa !== (k == 2)) begin n_err++; $display("FAIL lim_ejeta_%0d got %0d exp %0d", k, ejeta_tentativa, (k == 2)); end
            n_cmp++; if (tentativas !== 2'(k + 1)) begin n_err++; $display("FAIL lim_tentativas_%0d got %0d exp %0d", k, tentativas, k + 1); end
        end
        tick();
        n_cmp++; if (ejeta_tentativa !== 1'b0) begin n_err++; $display("FAIL lim_ejeta_width got %0d exp 0", ejeta_tentativa); end
        press_digit(4'd1);
        n_cmp++; if (n_digitos !== 3'd3) begin n_err++; $display("FAIL lim_ejeta_digit_ignored got %0d exp 3", n_digitos); end
        pulse_confirma(); tick();
        n_cmp++; if (erro_pin !== 1'b0 || ejeta_tentativa !== 1'b0) begin n_err++; $display("FAIL lim_ejeta_confirm_ignored got %0d/%0d exp 0/0", erro_pin, ejeta_tentativa); end
        card_out();
        press_digit(4'd1);
        n_cmp++; if (n_digitos !== 3'd3) begin n_err++; $display("FAIL lim_espera_hold got %0d exp 3", n_digitos); end
        card_in();
        n_cmp++; if (tentativas !== 2'd0 || n_digitos !== 3'd0) begin n_err++; $display("FAIL lim_reentry_clear got %0d/%0d exp 0/0", tentativas, n_digitos); end
        card_out();
    endtask

    task automatic test_timeout();
        card_in();
        tick(); tick(); tick(); tick();
        n_cmp++; if (tempo !== 9'd16) begin n_err++; $display("FAIL to_decrement got %0d exp 16", tempo); end
        press_digit(4'd7);
        n_cmp++; if (tempo !== 9'd20) begin n_err++; $display("FAIL to_reload got %0d exp 20", tempo); end
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if (tempo !== 9'd0 || ejeta_tempo !== 1'b0) begin n_err++; $display("FAIL to_edge20 got %0d/%0d exp 0/0", tempo, ejeta_tempo); end
        press_digit(4'd3);
        n_cmp++; if (ejeta_tempo !== 1'b1) begin n_err++; $display("FAIL to_ejeta_tempo got %0d exp 1", ejeta_tempo); end
        n_cmp++; if (n_digitos !== 3'd1) begin n_err++; $display("FAIL to_digit_loses got %0d exp 1", n_digitos); end
        tick();
        n_cmp++; if (ejeta_tempo !== 1'b0) begin n_err++; $display("FAIL to_ejeta_width got %0d exp 0", ejeta_tempo); end
        card_out();
    endtask

    task automatic test_edge_inputs();
        card_in();
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4); press_digit(4'd5);
        n_cmp++; if (n_digitos !== 3'd4) begin n_err++; $display("FAIL edge_saturate got %0d exp 4", n_digitos); end
        n_cmp++; if (tempo !== 9'd19) begin n_err++; $display("FAIL edge_extra_no_reload got %0d exp 19", tempo); end
        cancela = 1'b1; tick(); cancela = 1'b0;
        n_cmp++; if (n_digitos !== 3'd0 || tempo !== 9'd20) begin n_err++; $display("FAIL edge_cancel got %0d/%0d exp 0/20", n_digitos, tempo); end
        press_digit(4'hA);
        n_cmp++; if (n_digitos !== 3'd0 || tempo !== 9'd19) begin n_err++; $display("FAIL edge_digit_A got %0d/%0d exp 0/19", n_digitos, tempo); end
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
        pulse_confirma(); tick();
        n_cmp++; if (erro_pin !== 1'b1 || tentativas !== 2'd1) begin n_err++; $display("FAIL edge_short_pin got %0d/%0d exp 1/1", erro_pin, tentativas); end
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
        cancela = 1'b1; confirma = 1'b1; tick(); cancela = 1'b0; confirma = 1'b0;
        tick();
        n_cmp++; if (autorizado !== 1'b0 || erro_pin !== 1'b0) begin n_err++; $display("FAIL edge_cancel_confirm got %0d/%0d exp 0/0", autorizado, erro_pin); end
        n_cmp++; if (n_digitos !== 3'd0 || tentativas !== 2'd1) begin n_err++; $display("FAIL edge_cancel_confirm_cnt got %0d/%0d exp 0/1", n_digitos, tentativas); end
        card_out();
    endtask

    task automatic test_abort();
        card_in();
        press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd5);
        pulse_confirma();
        cartao_in = 1'b0; tick();
        n_cmp++; if (erro_pin !== 1'b0 || ejeta_tentativa !== 1'b0) begin n_err++; $display("FAIL abort_no_pulse got %0d/%0d exp 0/0", erro_pin, ejeta_tentativa); end
        n_cmp++; if (tentativas !== 2'd0) begin n_err++; $display("FAIL abort_tentativas got %0d exp 0", tentativas); end
        press_digit(4'd6);
        n_cmp++; if (n_digitos !== 3'd4) begin n_err++; $display("FAIL abort_espera_hold got %0d exp 4", n_digitos); end
        card_in();
        press_digit(4'd1); press_digit(4'd2);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (n_digitos !== 3'd0 || tempo !== 9'd0) begin n_err++; $display("FAIL abort_async_reset got %0d/%0d exp 0/0", n_digitos, tempo); end
        n_cmp++; if (autorizado !== 1'b0 || ejeta_tempo !== 1'b0) begin n_err++; $display("FAIL abort_async_flags got %0d/%0d exp 0/0", autorizado, ejeta_tempo); end
        cartao_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_correct_pin();
        test_retry();
        test_attempt_limit();
        test_timeout();
        test_edge_inputs();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
